// File: rtl/mp_addsub_iter_if.sv
// Request/response bundle for mp_addsub_iter.
// Optional flag outputs (zero, a_lt_b) exist only when MPADD_FLAGS_EN is defined.
interface mp_addsub_iter_if #(
  parameter int WIDTH = 1027
) ();
  logic             start;
  logic             subtract;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH:0]   result;
  logic             done;
  logic             busy;
`ifdef MPADD_FLAGS_EN
  logic             zero;
  logic             a_lt_b;

  modport master (output start, subtract, in_a, in_b,
                  input  result, done, busy, zero, a_lt_b);
  modport slave  (input  start, subtract, in_a, in_b,
                  output result, done, busy, zero, a_lt_b);
`else
  modport master (output start, subtract, in_a, in_b,
                  input  result, done, busy);
  modport slave  (input  start, subtract, in_a, in_b,
                  output result, done, busy);
`endif
endinterface

// File: rtl/mp_addsub_iter.sv
// Chunk-serial multi-precision adder/subtractor.
// Operands are zero-extended to NCHUNK*CHUNK bits and consumed CHUNK bits per
// cycle, low chunk first, with the carry registered between chunks.
// Optional macro MPADD_FLAGS_EN adds registered zero / a_lt_b flags.
module mp_addsub_iter #(
  parameter int WIDTH = 1027,
  parameter int CHUNK = 64
) (
  input  logic             clk,
  input  logic             reset,
  mp_addsub_iter_if.slave  bus
);
  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int EXT    = NCHUNK * CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [EXT-1:0]  a_q, a_d;
  logic [EXT-1:0]  b_q, b_d;
  logic [EXT-1:0]  sum_q, sum_d;
  logic            top_q, top_d;
  logic            carry_q, carry_d;
  logic            sub_q, sub_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] s_chunk;
  logic             c_out;
  logic             last;
  logic [EXT:0]     full_q;

  // Operands shift right each RUN cycle, so the current chunk is always at the bottom.
  assign b_chunk          = sub_q ? ~b_q[CHUNK-1:0] : b_q[CHUNK-1:0];
  assign {c_out, s_chunk} = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_chunk}
                          + {{CHUNK{1'b0}}, carry_q};
  assign last             = (cnt_q == CW'(NCHUNK - 1));

  // Bit EXT of the extended sum: carry-out for add; for subtract the infinite
  // ~B extension contributes a 1 above the top chunk, so the bit is ~carry.
  assign full_q      = {top_q, sum_q};
  assign bus.result  = full_q[WIDTH:0];
  assign bus.done    = (state_q == DONE);
  assign bus.busy    = (state_q != IDLE);

`ifdef MPADD_FLAGS_EN
  logic zacc_q, zacc_d;
  logic zero_q, zero_d;
  logic lt_q, lt_d;
  logic [EXT:0] full_next;

  assign full_next  = {c_out ^ sub_q, sum_d};
  assign bus.zero   = zero_q;
  assign bus.a_lt_b = lt_q;
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    top_d   = top_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    cnt_d   = cnt_q;
`ifdef MPADD_FLAGS_EN
    zacc_d  = zacc_q;
    zero_d  = zero_q;
    lt_d    = lt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = EXT'(bus.in_a);
          b_d     = EXT'(bus.in_b);
          sub_d   = bus.subtract;
          carry_d = bus.subtract;
          cnt_d   = '0;
          state_d = RUN;
`ifdef MPADD_FLAGS_EN
          zacc_d  = 1'b1;
`endif
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        sum_d   = EXT'({s_chunk, sum_q} >> CHUNK);
        carry_d = c_out;
        cnt_d   = cnt_q + CW'(1);
`ifdef MPADD_FLAGS_EN
        zacc_d  = zacc_q & (s_chunk == '0);
`endif
        if (last) begin
          top_d   = c_out ^ sub_q;
          state_d = DONE;
`ifdef MPADD_FLAGS_EN
          // |A-B| and A+B fit below bit WIDTH+1, so the low WIDTH+1 bits are
          // zero exactly when the whole extended sum is zero.
          zero_d  = zacc_q & (s_chunk == '0) & ~(c_out ^ sub_q);
          lt_d    = sub_q & full_next[WIDTH];
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      top_q   <= 1'b0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef MPADD_FLAGS_EN
      zacc_q  <= 1'b0;
      zero_q  <= 1'b0;
      lt_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      top_q   <= top_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      cnt_q   <= cnt_d;
`ifdef MPADD_FLAGS_EN
      zacc_q  <= zacc_d;
      zero_q  <= zero_d;
      lt_q    <= lt_d;
`endif
    end
  end
endmodule

// File: tb/tb_mp_addsub_iter.sv
// Directed bench for mp_addsub_iter: default, WIDTH=8/CHUNK=3 and WIDTH=CHUNK=16.
module tb_mp_addsub_iter;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mp_addsub_iter_if #(.WIDTH(1027)) b0 ();
  mp_addsub_iter_if #(.WIDTH(8))    b1 ();
  mp_addsub_iter_if #(.WIDTH(16))   b2 ();

  mp_addsub_iter #(.WIDTH(1027), .CHUNK(64)) u0 (.clk(clk), .reset(reset), .bus(b0));
  mp_addsub_iter #(.WIDTH(8),    .CHUNK(3))  u1 (.clk(clk), .reset(reset), .bus(b1));
  mp_addsub_iter #(.WIDTH(16),   .CHUNK(16)) u2 (.clk(clk), .reset(reset), .bus(b2));

  task automatic chk(input string tag, input logic [1027:0] got, input logic [1027:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h..%h exp=%h..%h", tag, got[1027:1024], got[127:0],
               exp[1027:1024], exp[127:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation on the default instance; start in cycle 0, observe to cycle 25.
  task automatic run0(input string tag, input logic sub, input logic [1026:0] a,
                      input logic [1026:0] b, input logic [1027:0] exp,
                      input logic ez, input logic elt);
    int lat = -1, nd = 0, nb = 0;
    logic [1027:0] r = '0;
    logic fz = 1'b0, flt = 1'b0;
    for (int c = 0; c <= 25; c++) begin
      b0.start = (c == 0);
      if (c == 0) begin
        b0.subtract = sub; b0.in_a = a; b0.in_b = b;
      end
      @(negedge clk);
      if (b0.busy) nb++;
      if (b0.done) begin
        nd++; lat = c; r = b0.result;
`ifdef MPADD_FLAGS_EN
        fz = b0.zero; flt = b0.a_lt_b;
`endif
      end
      tick();
    end
    chk({tag, ".lat"},  lat, 18);
    chk({tag, ".ndone"}, nd, 1);
    chk({tag, ".nbusy"}, nb, 18);
    chk({tag, ".res"},  r, exp);
`ifdef MPADD_FLAGS_EN
    chk({tag, ".zero"}, fz, ez);
    chk({tag, ".lt"},   flt, elt);
`else
    if (ez === 1'bx || elt === 1'bx) $display("flag args unknown in %s", tag);
`endif
  endtask

  task automatic run1(input string tag, input logic sub, input logic [7:0] a,
                      input logic [7:0] b, input logic [8:0] exp);
    int lat = -1;
    logic [8:0] r = '0;
    for (int c = 0; c <= 8; c++) begin
      b1.start = (c == 0);
      if (c == 0) begin
        b1.subtract = sub; b1.in_a = a; b1.in_b = b;
      end
      @(negedge clk);
      if (b1.done && lat < 0) begin lat = c; r = b1.result; end
      tick();
    end
    chk({tag, ".lat"}, lat, 4);
    chk({tag, ".res"}, r, exp);
  endtask

  task automatic run2(input string tag, input logic sub, input logic [15:0] a,
                      input logic [15:0] b, input logic [16:0] exp);
    int lat = -1;
    logic [16:0] r = '0;
    for (int c = 0; c <= 6; c++) begin
      b2.start = (c == 0);
      if (c == 0) begin
        b2.subtract = sub; b2.in_a = a; b2.in_b = b;
      end
      @(negedge clk);
      if (b2.done && lat < 0) begin lat = c; r = b2.result; end
      tick();
    end
    chk({tag, ".lat"}, lat, 2);
    chk({tag, ".res"}, r, exp);
  endtask

  initial begin
    logic [1026:0] ones;
    logic [1027:0] e;
    int nd, dc0, dc1;
    logic [1027:0] r0, r1;

    reset = 1'b1;
    b0.start = 0; b0.subtract = 0; b0.in_a = '0; b0.in_b = '0;
    b1.start = 0; b1.subtract = 0; b1.in_a = '0; b1.in_b = '0;
    b2.start = 0; b2.subtract = 0; b2.in_a = '0; b2.in_b = '0;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst.res",  b0.result, 0);
    chk("rst.busy", b0.busy, 0);
    chk("rst.done", b0.done, 0);
    chk("rst.res8", b1.result, 0);
    tick();

    // 1: basic add
    run0("add11", 1'b0, 1027'd1, 1027'd1, 1028'd2, 1'b0, 1'b0);

    // 2: carry ripples across every chunk boundary
    ones = '1;
    e = '0; e[1027] = 1'b1;
    run0("carry", 1'b0, ones, 1027'd1, e, 1'b0, 1'b0);

    // 3: subtract with borrow, and equal operands
    e = '1;
    run0("sub01", 1'b1, 1027'd0, 1027'd1, e, 1'b0, 1'b1);
    run0("sub55", 1'b1, 1027'd5, 1027'd5, 1028'd0, 1'b1, 1'b0);
    // mixed pattern spanning chunks: (2^1026 + 2^100 + 7) - (2^64 + 9)
    e = '0; e[1025:0] = '1; e[1025:64] = '0; e[100] = 1'b1; e[64] = 1'b0;
    e = ({1'b0, 1027'd1 << 1026} + (1028'd1 << 100) + 1028'd7)
        - ((1028'd1 << 64) + 1028'd9);
    run0("submix", 1'b1, (1027'd1 << 1026) + (1027'd1 << 100) + 1027'd7,
         (1027'd1 << 64) + 1027'd9, e, 1'b0, 1'b0);

    // 4: start held high; second op accepted only after DONE
    nd = 0; dc0 = -1; dc1 = -1; r0 = '0; r1 = '0;
    b0.subtract = 1'b0; b0.in_b = 1027'd3;
    for (int c = 0; c <= 45; c++) begin
      b0.start = (c <= 25);
      b0.in_a  = (c >= 5) ? 1027'd99 : 1027'd10;
      @(negedge clk);
      if (c == 19) chk("hold.busy19", b0.busy, 0);
      if (b0.done) begin
        if (nd == 0) begin dc0 = c; r0 = b0.result; end
        else if (nd == 1) begin dc1 = c; r1 = b0.result; end
        nd++;
      end
      tick();
    end
    chk("hold.ndone", nd, 2);
    chk("hold.dc0", dc0, 18);
    chk("hold.r0", r0, 13);
    chk("hold.dc1", dc1, 37);
    chk("hold.r1", r1, 102);

    // 5: reset aborts a running add
    nd = 0; dc0 = -1; r0 = '0;
    b0.subtract = 1'b0; b0.in_a = 1027'd7; b0.in_b = 1027'd8;
    for (int c = 0; c <= 35; c++) begin
      b0.start = (c == 0 || c == 10);
      reset    = (c == 8);
      @(negedge clk);
      if (c == 9) begin
        chk("abort.busy", b0.busy, 0);
        chk("abort.res",  b0.result, 0);
      end
      if (b0.done) begin nd++; dc0 = c; r0 = b0.result; end
      tick();
    end
    chk("abort.ndone", nd, 1);
    chk("abort.dc", dc0, 28);
    chk("abort.res2", r0, 15);

    // 6: small instances, partial last chunk and single chunk
    run1("w8add", 1'b0, 8'd200, 8'd100, 9'h12C);
    run1("w8max", 1'b0, 8'd255, 8'd255, 9'h1FE);
    run1("w8sub", 1'b1, 8'd3,   8'd5,   9'h1FE);
    run2("w16sub", 1'b1, 16'd1, 16'd2,  17'h1FFFF);
    run2("w16add", 1'b0, 16'hFFFF, 16'h0001, 17'h10000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
